// File: rtl/sc_pkg.sv
// Shared definitions for the single-cycle CPU front end.
//   - PCSRC_* : encodings of the control unit's next-PC select
//   - word_t  : 32-bit machine word
//   - fetch_state_e : instruction-fetch FSM states
package sc_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/sc_next_pc.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc_i        current instruction address
//   pcsource_i  select: seq / branch / jr / j
//   imm32_i     sign-extended branch offset, in words
//   ra_i        jr target register value
//   target_i    26-bit jump target field of the instruction
//   next_pc_o   selected next PC
//   pc4_o       pc_i + 4 (also the jal link value)
module sc_next_pc
  import sc_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pcsource_i,
  input  logic [31:0] imm32_i,
  input  logic [31:0] ra_i,
  input  logic [25:0] target_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pc4_o
);

  word_t brTarget;

  always_comb begin
    pc4_o    = pc_i + 32'd4;
    // Branch offset counts words, so scale to bytes before adding.
    brTarget = pc4_o + {imm32_i[29:0], 2'b00};
    next_pc_o = pc4_o;
    case (pcsource_i)
      PCSRC_SEQ: next_pc_o = pc4_o;
      PCSRC_BR:  next_pc_o = brTarget;
      // Low bits are dropped so a jr can never produce a misaligned fetch.
      PCSRC_JR:  next_pc_o = ra_i & 32'hFFFF_FFFC;
      PCSRC_J:   next_pc_o = {pc4_o[31:28], target_i, 2'b00};
      default:   next_pc_o = pc4_o;
    endcase
  end

endmodule

// File: rtl/sc_ifetch.sv
// Instruction-fetch stage: holds the PC, fetches from a wait-stated
// instruction memory over a req/ack handshake and presents the word
// to the decoder until the datapath signals advance.
// Ports:
//   clock, resetn            clock and async active-low reset
//   pcsource, imm32, ra      next-PC select and operands
//   advance                  current instruction retired, commit next PC
//   imem_req/addr/ack/rdata  instruction memory handshake
//   pc, pc4, inst, inst_valid current instruction view
//   inst_count               retired-instruction counter
//   fetch_fault              sticky misaligned-jr fault
// Build option: SC_IFETCH_ALIGN_CHECK_EN enables the misaligned jr
// check (fault + HALT); otherwise fetch_fault is tied low.
module sc_ifetch
  import sc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [1:0]       pcsource,
  input  logic [31:0]      imm32,
  input  logic [31:0]      ra,
  input  logic             advance,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic [31:0]      inst,
  output logic             inst_valid,
  output logic [CNT_W-1:0] inst_count,
  output logic             fetch_fault
);

  fetch_state_e     state_q;
  word_t            pc_q;
  word_t            inst_q;
  logic             instValid_q;
  logic             imemReq_q;
  logic [CNT_W-1:0] instCount_q;
  word_t            nextPc_d;

  sc_next_pc uNextPc (
    .pc_i       (pc_q),
    .pcsource_i (pcsource),
    .imm32_i    (imm32),
    .ra_i       (ra),
    .target_i   (inst_q[25:0]),
    .next_pc_o  (nextPc_d),
    .pc4_o      (pc4)
  );

`ifdef SC_IFETCH_ALIGN_CHECK_EN
  logic fault_q;
  logic jrMisaligned;
  assign jrMisaligned = (pcsource == PCSRC_JR) && (ra[1:0] != 2'b00);
  assign fetch_fault  = fault_q;
`else
  assign fetch_fault  = 1'b0;
`endif

  // Fetch FSM. All handshake and status outputs are registered here;
  // acks outside FETCH and advances outside HOLD fall through untouched.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      instValid_q <= 1'b0;
      imemReq_q   <= 1'b0;
      instCount_q <= '0;
`ifdef SC_IFETCH_ALIGN_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          imemReq_q <= 1'b1;
          state_q   <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            inst_q      <= imem_rdata;
            instValid_q <= 1'b1;
            imemReq_q   <= 1'b0;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (advance) begin
            instCount_q <= instCount_q + CNT_W'(1);
            instValid_q <= 1'b0;
`ifdef SC_IFETCH_ALIGN_CHECK_EN
            // A misaligned jr still retires but parks the stage until reset.
            if (jrMisaligned) begin
              fault_q <= 1'b1;
              state_q <= HALT;
            end else begin
              pc_q      <= nextPc_d;
              imemReq_q <= 1'b1;
              state_q   <= FETCH;
            end
`else
            pc_q      <= nextPc_d;
            imemReq_q <= 1'b1;
            state_q   <= FETCH;
`endif
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req   = imemReq_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = instValid_q;
  assign inst_count = instCount_q;

endmodule

// File: tb/tb_sc_ifetch.sv
// Self-checking bench for sc_ifetch. A reference model tracks the
// expected PC, instruction and retire count; memory wait states,
// instruction words and next-PC selects are randomized.
module tb_sc_ifetch;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] imm32 = '0;
  logic [31:0] ra = '0;
  logic        advance = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] inst_count;
  logic        fetch_fault;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expPc = '0;
  logic [31:0] expInst = '0;
  logic [31:0] expCount = '0;

  sc_ifetch dut (
    .clock(clock), .resetn(resetn), .pcsource(pcsource), .imm32(imm32),
    .ra(ra), .advance(advance), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .pc4(pc4),
    .inst(inst), .inst_valid(inst_valid), .inst_count(inst_count),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  // Next PC from the instruction-set rules, in plain arithmetic.
  function automatic logic [31:0] refNext(input logic [1:0] src, input logic [31:0] pcv,
                                          input logic [31:0] instv, input logic [31:0] immv,
                                          input logic [31:0] rav);
    logic [31:0] seq;
    seq = pcv + 32'd4;
    case (src)
      2'd0:    return seq;
      2'd1:    return seq + immv * 32'd4;
      2'd2:    return rav - (rav % 32'd4);
      2'd3:    return (seq & 32'hF000_0000) + (instv % 32'h0400_0000) * 32'd4;
      default: return seq;
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expects the DUT in FETCH at expPc; serves the request after waitCycles.
  task automatic do_fetch(input int waitCycles, input logic [31:0] word, input logic holdAdvance);
    logic [31:0] expPc4;
    expPc4 = expPc + 32'd4;
    total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL fetch_req: got %0b expected 1", imem_req); end
    total++; if (imem_addr !== expPc) begin bad++; $display("[TB] FAIL fetch_addr: got %h expected %h", imem_addr, expPc); end
    advance = holdAdvance;
    for (int i = 0; i < waitCycles; i++) begin
      imem_ack = 1'b0;
      step();
      total++; if (imem_req !== 1'b1 || inst_valid !== 1'b0 || pc !== expPc) begin
        bad++; $display("[TB] FAIL fetch_wait: got req=%0b valid=%0b pc=%h expected req=1 valid=0 pc=%h", imem_req, inst_valid, pc, expPc);
      end
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    advance = 1'b0;
    imem_rdata = $urandom;
    expInst = word;
    total++; if (inst !== word || inst_valid !== 1'b1) begin
      bad++; $display("[TB] FAIL fetch_inst: got inst=%h valid=%0b expected inst=%h valid=1", inst, inst_valid, word);
    end
    total++; if (imem_req !== 1'b0 || pc !== expPc || pc4 !== expPc4) begin
      bad++; $display("[TB] FAIL fetch_hold: got req=%0b pc=%h pc4=%h expected req=0 pc=%h pc4=%h", imem_req, pc, pc4, expPc, expPc4);
    end
    total++; if (inst_count !== expCount) begin bad++; $display("[TB] FAIL fetch_count: got %0d expected %0d", inst_count, expCount); end
  endtask

  // Expects the DUT in HOLD; retires the instruction with the given select.
  task automatic do_advance(input logic [1:0] src, input logic [31:0] immV, input logic [31:0] raV);
    logic [31:0] nxt;
    nxt = refNext(src, expPc, expInst, immV, raV);
    pcsource = src; imm32 = immV; ra = raV; advance = 1'b1;
    step();
    advance = 1'b0;
    expPc = nxt;
    expCount = expCount + 32'd1;
    total++; if (pc !== expPc || imem_addr !== expPc) begin
      bad++; $display("[TB] FAIL adv_pc: src=%0d got pc=%h addr=%h expected %h", src, pc, imem_addr, expPc);
    end
    total++; if (imem_req !== 1'b1 || inst_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      bad++; $display("[TB] FAIL adv_ctrl: got req=%0b valid=%0b fault=%0b expected 1 0 0", imem_req, inst_valid, fetch_fault);
    end
    total++; if (inst_count !== expCount) begin bad++; $display("[TB] FAIL adv_count: got %0d expected %0d", inst_count, expCount); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) step();
    total++; if (pc !== 32'h0 || inst !== 32'h0 || inst_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_state: got pc=%h inst=%h valid=%0b expected 0 0 0", pc, inst, inst_valid);
    end
    total++; if (imem_req !== 1'b0 || inst_count !== 32'h0 || fetch_fault !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_ctrl: got req=%0b count=%0d fault=%0b expected 0 0 0", imem_req, inst_count, fetch_fault);
    end
    resetn = 1'b1;
    advance = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_req: got %0b expected 0", imem_req); end
    step();
    advance = 1'b0;
    expPc = 32'h0; expCount = 32'h0; expInst = 32'h0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc !== 32'h0) begin
      bad++; $display("[TB] FAIL first_req: got req=%0b addr=%h pc=%h expected 1 0 0", imem_req, imem_addr, pc);
    end
  endtask

  task automatic test_first_fetch();
    // advance held through FETCH, including the ack edge, must be ignored.
    do_fetch(3, 32'h2008_0005, 1'b1);
    total++; if (pc4 !== 32'h4) begin bad++; $display("[TB] FAIL first_pc4: got %h expected 4", pc4); end
  endtask

  task automatic test_sequential();
    do_advance(2'b00, 32'h0, 32'h0);
    total++; if (pc !== 32'h4 || inst_count !== 32'd1) begin
      bad++; $display("[TB] FAIL seq_pc: got pc=%h count=%0d expected 4 1", pc, inst_count);
    end
  endtask

  task automatic test_branch();
    do_fetch(1, $urandom, 1'b0);
    do_advance(2'b10, 32'h0, 32'h0000_0010);
    do_fetch(0, $urandom, 1'b0);
    do_advance(2'b01, 32'hFFFF_FFFE, 32'h0);
    total++; if (pc !== 32'h0000_000C) begin bad++; $display("[TB] FAIL branch_back: got %h expected 0000000c", pc); end
    do_fetch(2, $urandom, 1'b0);
    do_advance(2'b10, 32'h0, 32'h0000_0010);
    do_fetch(0, $urandom, 1'b0);
    do_advance(2'b01, 32'h0000_0003, 32'h0);
    total++; if (pc !== 32'h0000_0020) begin bad++; $display("[TB] FAIL branch_fwd: got %h expected 00000020", pc); end
  endtask

  task automatic test_jump();
    do_fetch(0, $urandom, 1'b0);
    do_advance(2'b10, 32'h0, 32'h1000_0000);
    do_fetch(1, 32'h0C00_0040, 1'b0);
    do_advance(2'b11, 32'h0, 32'h0);
    total++; if (pc !== 32'h1000_0100) begin bad++; $display("[TB] FAIL jump: got %h expected 10000100", pc); end
    do_fetch(0, $urandom, 1'b0);
    do_advance(2'b10, 32'h0, 32'h0000_0080);
    total++; if (pc !== 32'h0000_0080) begin bad++; $display("[TB] FAIL jr: got %h expected 00000080", pc); end
  endtask

  task automatic test_wrap();
    do_fetch(0, $urandom, 1'b0);
    do_advance(2'b10, 32'h0, 32'hFFFF_FFFC);
    do_fetch(0, $urandom, 1'b0);
    total++; if (pc4 !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc4: got %h expected 0", pc4); end
    do_advance(2'b00, 32'h0, 32'h0);
    total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc: got %h expected 0", pc); end
  endtask

  task automatic test_spurious_ack();
    logic [31:0] w;
    w = $urandom;
    do_fetch(0, w, 1'b0);
    imem_ack = 1'b1;
    imem_rdata = ~w;
    step();
    imem_ack = 1'b0;
    total++; if (inst !== w || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
      bad++; $display("[TB] FAIL spurious_ack: got inst=%h valid=%0b req=%0b expected inst=%h valid=1 req=0", inst, inst_valid, imem_req, w);
    end
    do_advance(2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] raV;
    for (int i = 0; i < 40; i++) begin
      do_fetch($urandom_range(0, 3), $urandom, 1'(($urandom_range(0, 1))));
`ifdef SC_IFETCH_ALIGN_CHECK_EN
      raV = $urandom & 32'hFFFF_FFFC;
`else
      raV = $urandom;
`endif
      do_advance(2'($urandom_range(0, 3)), $urandom, raV);
    end
  endtask

  task automatic test_reset_mid_fetch();
    step();
    resetn = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || pc !== 32'h0 || inst_count !== 32'h0 || inst_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL midreset: got req=%0b pc=%h count=%0d valid=%0b expected 0 0 0 0", imem_req, pc, inst_count, inst_valid);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    resetn = 1'b1;
    step();
    imem_ack = 1'b0;
    expPc = 32'h0; expCount = 32'h0; expInst = 32'h0;
    total++; if (inst !== 32'h0 || inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("[TB] FAIL late_ack: got inst=%h valid=%0b req=%0b addr=%h expected 0 0 1 0", inst, inst_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_misaligned_jr();
    do_fetch(1, $urandom, 1'b0);
    pcsource = 2'b10; ra = 32'h0000_0082; advance = 1'b1;
    step();
    advance = 1'b0;
    expCount = expCount + 32'd1;
`ifdef SC_IFETCH_ALIGN_CHECK_EN
    total++; if (fetch_fault !== 1'b1 || pc !== expPc || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++; $display("[TB] FAIL misalign_fault: got fault=%0b pc=%h valid=%0b req=%0b expected 1 %h 0 0", fetch_fault, pc, inst_valid, imem_req, expPc);
    end
    total++; if (inst_count !== expCount) begin bad++; $display("[TB] FAIL misalign_count: got %0d expected %0d", inst_count, expCount); end
    advance = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (imem_req !== 1'b0 || fetch_fault !== 1'b1 || pc !== expPc) begin
        bad++; $display("[TB] FAIL halt_stuck: got req=%0b fault=%0b pc=%h expected 0 1 %h", imem_req, fetch_fault, pc, expPc);
      end
    end
    advance = 1'b0; imem_ack = 1'b0;
`else
    total++; if (pc !== 32'h0000_0080 || fetch_fault !== 1'b0 || imem_req !== 1'b1) begin
      bad++; $display("[TB] FAIL misalign_masked: got pc=%h fault=%0b req=%0b expected 00000080 0 1", pc, fetch_fault, imem_req);
    end
    total++; if (inst_count !== expCount) begin bad++; $display("[TB] FAIL misalign_count: got %0d expected %0d", inst_count, expCount); end
`endif
  endtask

  initial begin
    $display("[TB] starting sc_ifetch bench");
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap();
    test_spurious_ack();
    test_random();
    test_reset_mid_fetch();
    test_misaligned_jr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
